hex_game_ctrl: RTL

//  Sequencer for the dual 4-digit hex store (set-code store + guess store) in the code-guessing game.
//  - Owns the store control lines: enter gating, store select and store reset.
//  - Runs a game in order: code entry, then repeated guesses, scoring each guess, then win or lose.
//  - Scores each guess Mastermind-style: exact and partial digit matches.
//  - Sits between the debounced buttons and the store; its outputs drive the 7-seg/LED display logic.

---
 rtl/game_pkg.sv | 27 ++
 rtl/hex_match_counter.sv | 72 +++++++
 rtl/hex_game_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared constants, state encoding and digit helpers for the code-guessing game.
package game_pkg;

   localparam int NUM_DIGITS = 4;
   localparam int DIGIT_W    = 4;
   localparam int CODE_W     = NUM_DIGITS * DIGIT_W;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SET_CODE  = 3'd1,
      S_GUESS     = 3'd2,
      S_CHK_EXACT = 3'd3,
      S_CHK_PART  = 3'd4,
      S_RESULT    = 3'd5,
      S_WIN       = 3'd6,
      S_LOSE      = 3'd7
   } state_e;

   function automatic logic [DIGIT_W-1:0] digit(input logic [CODE_W-1:0] code, input int k);
      return code[k*DIGIT_W +: DIGIT_W];
   endfunction

   function automatic logic [2:0] popcount4(input logic [NUM_DIGITS-1:0] m);
      return {2'b00, m[0]} + {2'b00, m[1]} + {2'b00, m[2]} + {2'b00, m[3]};
   endfunction

endpackage

// File: rtl/hex_match_counter.sv
// Mastermind scoring: one cycle for exact matches, then one guess digit per cycle
// for partial matches against the lowest still-unused set digit.
module hex_match_counter
   import game_pkg::*;
(
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              clr_i,
   input  logic              start_chk_i,
   input  logic [CODE_W-1:0] set_code_i,
   input  logic [CODE_W-1:0] guess_code_i,
   output logic              done_o,
   output logic [2:0]        exact_cnt_o,
   output logic [2:0]        partial_cnt_o
);

   logic [NUM_DIGITS-1:0] exact_mask_q, exact_mask_d;
   logic [NUM_DIGITS-1:0] used_mask_q, used_mask_d;
   logic [1:0]            idx_q;
   logic                  busy_q;
   logic [2:0]            exact_q, partial_q;
   logic                  found;

   always_comb begin
      exact_mask_d = '0;
      for (int k = 0; k < NUM_DIGITS; k++)
         exact_mask_d[k] = (digit(set_code_i, k) == digit(guess_code_i, k));
   end

   // Exact positions start out used, so they can never be claimed as partials.
   always_comb begin
      found       = 1'b0;
      used_mask_d = used_mask_q;
      if (!exact_mask_q[idx_q]) begin
         for (int j = 0; j < NUM_DIGITS; j++) begin
            if (!found && !used_mask_q[j] &&
                digit(set_code_i, j) == digit(guess_code_i, int'(idx_q))) begin
               found          = 1'b1;
               used_mask_d[j] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i || clr_i) begin
         exact_mask_q <= '0;
         used_mask_q  <= '0;
         idx_q        <= '0;
         busy_q       <= 1'b0;
         exact_q      <= '0;
         partial_q    <= '0;
      end else if (start_chk_i) begin
         exact_mask_q <= exact_mask_d;
         used_mask_q  <= exact_mask_d;
         exact_q      <= popcount4(exact_mask_d);
         partial_q    <= '0;
         idx_q        <= '0;
         busy_q       <= 1'b1;
      end else if (busy_q) begin
         used_mask_q <= used_mask_d;
         if (found) partial_q <= partial_q + 3'd1;
         idx_q <= idx_q + 2'd1;
         if (idx_q == 2'd3) busy_q <= 1'b0;
      end
   end

   assign done_o        = busy_q && (idx_q == 2'd3);
   assign exact_cnt_o   = exact_q;
   assign partial_cnt_o = partial_q;

endmodule

// File: rtl/hex_game_ctrl.sv
// Game sequencer: owns the hex store control lines, counts digits and attempts,
// and launches scoring of each completed guess.
module hex_game_ctrl
   import game_pkg::*;
#(
   parameter int MAX_ATTEMPTS = 8,
   parameter int ATTEMPT_W    = 4
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 start_i,
   input  logic                 enter_i,
   input  logic [CODE_W-1:0]    set_code_i,
   input  logic [CODE_W-1:0]    guess_code_i,
   output logic                 store_enter_o,
   output logic                 store_enable_o,
   output logic                 store_reset_o,
   output logic [2:0]           exact_cnt_o,
   output logic [2:0]           partial_cnt_o,
   output logic [ATTEMPT_W-1:0] attempts_o,
   output logic                 result_valid_o,
   output logic                 win_o,
   output logic                 lose_o,
   output logic [2:0]           state_o
);

   localparam logic [ATTEMPT_W-1:0] MAX_A = ATTEMPT_W'(MAX_ATTEMPTS);

   state_e               state_q;
   logic [2:0]           digit_cnt_q;
   logic [ATTEMPT_W-1:0] attempts_q;
   logic                 start_acc, entry, chk_done;

   // A new game may only begin once the previous one is idle or scored.
   assign start_acc = start_i && (state_q inside {S_IDLE, S_RESULT, S_WIN, S_LOSE});
   assign entry     = (state_q == S_SET_CODE) || (state_q == S_GUESS);

   hex_match_counter u_match (
      .clk_i        (clk_i),
      .reset_i      (reset_i),
      .clr_i        (start_acc),
      .start_chk_i  (state_q == S_CHK_EXACT),
      .set_code_i   (set_code_i),
      .guess_code_i (guess_code_i),
      .done_o       (chk_done),
      .exact_cnt_o  (exact_cnt_o),
      .partial_cnt_o(partial_cnt_o)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         digit_cnt_q <= '0;
         attempts_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
               if (start_i) begin
                  state_q     <= S_SET_CODE;
                  digit_cnt_q <= '0;
                  attempts_q  <= '0;
               end
            end
            S_SET_CODE: begin
               if (enter_i) begin
                  if (digit_cnt_q == 3'd3) begin
                     state_q     <= S_GUESS;
                     digit_cnt_q <= '0;
                  end else begin
                     digit_cnt_q <= digit_cnt_q + 3'd1;
                  end
               end
            end
            S_GUESS: begin
               if (enter_i) begin
                  if (digit_cnt_q == 3'd3) begin
                     state_q     <= S_CHK_EXACT;
                     digit_cnt_q <= '0;
                  end else begin
                     digit_cnt_q <= digit_cnt_q + 3'd1;
                  end
               end
            end
            S_CHK_EXACT: begin
               if (attempts_q != MAX_A) attempts_q <= attempts_q + ATTEMPT_W'(1);
               state_q <= S_CHK_PART;
            end
            S_CHK_PART: begin
               if (chk_done) begin
                  if (exact_cnt_o == 3'd4)     state_q <= S_WIN;
                  else if (attempts_q == MAX_A) state_q <= S_LOSE;
                  else                          state_q <= S_RESULT;
               end
            end
            S_RESULT: begin
               if (start_i) begin
                  state_q     <= S_SET_CODE;
                  digit_cnt_q <= '0;
                  attempts_q  <= '0;
               end else if (enter_i) begin
                  state_q     <= S_GUESS;
                  digit_cnt_q <= '0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign store_enter_o  = enter_i && entry && !reset_i;
   assign store_enable_o = (state_q == S_GUESS);
   assign store_reset_o  = reset_i || start_acc;
   assign attempts_o     = attempts_q;
   assign result_valid_o = state_q inside {S_RESULT, S_WIN, S_LOSE};
   assign win_o          = (state_q == S_WIN);
   assign lose_o         = (state_q == S_LOSE);
   assign state_o        = state_q;

endmodule
